// File: rtl/peripheral_bus_master.sv
// Wishbone classic slave that turns each transfer into one peripheral bus access,
// holding strobes across the device busy window and reporting ack, error or timeout.
module peripheral_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [15:0] wb_adr_i,
   input  logic [31:0] wb_data_i,
   output logic        wb_ack_o,
   output logic        wb_error_o,
   output logic [31:0] wb_data_o,
   output logic        peripheralEnable,
   output logic        peripheralBus_we,
   output logic        peripheralBus_oe,
   output logic [15:0] peripheralBus_address,
   output logic [3:0]  peripheralBus_byteSelect,
   output logic [31:0] peripheralBus_dataWrite,
   input  logic        peripheralBus_busy,
   input  logic [31:0] peripheralBus_dataRead,
   input  logic        requestOutput
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACCESS  = 2'd1;
   localparam logic [1:0] ST_RESPOND = 2'd2;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [1:0] state;
   logic [7:0] timeout_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         state                    <= ST_IDLE;
         timeout_count            <= 8'd0;
         wb_ack_o                 <= 1'b0;
         wb_error_o               <= 1'b0;
         wb_data_o                <= 32'd0;
         peripheralEnable         <= 1'b0;
         peripheralBus_we         <= 1'b0;
         peripheralBus_oe         <= 1'b0;
         peripheralBus_address    <= 16'd0;
         peripheralBus_byteSelect <= 4'd0;
         peripheralBus_dataWrite  <= 32'd0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below reads
         // the pre-edge register values regardless of statement order.
         wb_ack_o   <= 1'b0;
         wb_error_o <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (wb_cyc_i && wb_stb_i) begin
                  peripheralBus_address    <= wb_adr_i;
                  peripheralBus_byteSelect <= wb_sel_i;
                  peripheralBus_dataWrite  <= wb_data_i;
                  peripheralEnable         <= 1'b1;
                  peripheralBus_we         <= wb_we_i;
                  peripheralBus_oe         <= ~wb_we_i;
                  timeout_count            <= 8'd0;
                  state                    <= ST_ACCESS;
               end
            end

            ST_ACCESS: begin
               // peripheralBus_we doubles as the latched direction while in ACCESS.
               if (!wb_cyc_i) begin
                  peripheralEnable <= 1'b0;
                  peripheralBus_we <= 1'b0;
                  peripheralBus_oe <= 1'b0;
                  state            <= ST_IDLE;
               end else if (!peripheralBus_busy) begin
                  peripheralEnable <= 1'b0;
                  peripheralBus_we <= 1'b0;
                  peripheralBus_oe <= 1'b0;
                  if (peripheralBus_we) begin
                     wb_ack_o <= 1'b1;
                  end else begin
                     wb_data_o  <= peripheralBus_dataRead;
                     wb_ack_o   <= requestOutput;
                     wb_error_o <= ~requestOutput;
                  end
                  state <= ST_RESPOND;
               end else if (timeout_count == TIMEOUT_LIMIT) begin
                  peripheralEnable <= 1'b0;
                  peripheralBus_we <= 1'b0;
                  peripheralBus_oe <= 1'b0;
                  wb_error_o       <= 1'b1;
                  wb_data_o        <= 32'hFFFF_FFFF;
                  state            <= ST_RESPOND;
               end else begin
                  timeout_count <= timeout_count + 8'd1;
               end
            end

            // Response flag was raised on entry; this cycle only returns to IDLE.
            ST_RESPOND: state <= ST_IDLE;

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/peripheral_bus_master.md
# peripheral_bus_master

Initiator end of the internal peripheral bus: accepts single Wishbone classic transfers from the core interconnect and turns each one into exactly one peripheral bus access. It drives peripheralEnable, address, byte selects, write data and the we/oe strobes shared by all peripheral devices. It then waits out peripheralBus_busy and returns read data, an acknowledge, or an error to the Wishbone side. There is one instance per peripheral cluster, sitting between the Wishbone slave decoder and the fan-out of device blocks.

## Interface
- TIMEOUT_CYCLES, 255: maximum busy cycles tolerated per access (1..255); an 8-bit counter is used.
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- wb_cyc_i  input  1  Wishbone cycle
- wb_stb_i  input  1  Wishbone strobe
- wb_we_i  input  1  1 = write
- wb_sel_i  input  4  byte selects
- wb_adr_i  input  16  byte address within peripheral space (bits [15:12] device ID, [11:0] local)
- wb_data_i  input  32  write data
- wb_ack_o  output  1  transfer complete, one cycle
- wb_error_o  output  1  transfer failed, one cycle (mutually exclusive with ack)
- wb_data_o  output  32  read data, valid with wb_ack_o
- peripheralEnable  output  1  access in progress
- peripheralBus_we  output  1  write strobe
- peripheralBus_oe  output  1  read strobe
- peripheralBus_address  output  16  latched wb_adr_i
- peripheralBus_byteSelect  output  4  latched wb_sel_i
- peripheralBus_dataWrite  output  32  latched wb_data_i
- peripheralBus_busy  input  1  OR of device busy flags
- peripheralBus_dataRead  input  32  muxed device read data
- requestOutput  input  1  some device decoded the read address

## Operation
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE: all peripheral outputs 0 except the latched address/sel/data, which hold their last value. When wb_cyc_i & wb_stb_i, latch adr/sel/data/we, clear the timeout counter, and go to ACCESS.
- ACCESS: peripheralEnable=1. peripheralBus_we = latched we; peripheralBus_oe = ~latched we.
  - Not busy: for a read, capture peripheralBus_dataRead into wb_data_o and set error = ~requestOutput. For a write, error = 0, since writes have no decode acknowledge. Go to RESPOND.
  - Busy: increment the counter. If the counter equals TIMEOUT_CYCLES while busy is still high, set error = 1, drive wb_data_o = 32'hFFFFFFFF, and go to RESPOND.
  - wb_cyc_i low: abort and go to IDLE with no ack and no error. A write may already have been committed by the device.
- RESPOND: peripheralEnable, we and oe are 0. Assert exactly one of wb_ack_o / wb_error_o for one cycle, then go to IDLE.
- An access leaves ACCESS only on busy low, timeout, or abort. Strobes are therefore held for the device's whole busy window, which devices rely on for back-to-back register writes.
- wb_data_o holds its value until the next read capture. On a read error it carries whatever the bus returned; devices return ~0 when undecoded.
- No pipelining: a new request is sampled only in IDLE. STB held high after the ack starts a new transfer on the following IDLE cycle.

## Timing
- Reset (synchronous, while rst high): state IDLE; wb_ack_o=0, wb_error_o=0, wb_data_o=0; peripheralEnable=0, peripheralBus_we=0, peripheralBus_oe=0; address=0, byteSelect=0, dataWrite=0; counter=0.
- Reset asserted in ACCESS drops all strobes on the next edge, and no response is issued.
- Zero-busy latency: request sampled at edge 0; strobes high during cycle 1; ack/error high during cycle 2; IDLE in cycle 3. Minimum spacing between transfers is 3 cycles.
- Busy for N cycles (N < TIMEOUT_CYCLES) extends ACCESS by N cycles, so the ack comes N+2 cycles after the request.
- Timeout: with busy stuck high, error is asserted in cycle TIMEOUT_CYCLES+2.
- Read data is sampled at the ACCESS edge on which busy is low. Device combinational read paths must settle within one cycle.

## Test plan
- Write 0x0000_00A5 to address 0x1004 with sel=4'b0001 and busy=0 -> we=1, enable=1 for exactly one cycle at cycle 1; address=0x1004, byteSelect=4'b0001; wb_ack_o in cycle 2; no error.
- Read 0x1080 with the device returning 0x0000_1234 and requestOutput=1 -> oe=1 for one cycle; wb_data_o=0x0000_1234 with wb_ack_o in cycle 2.
- Read with busy high for 3 cycles, then data 0xDEADBEEF -> oe held for 4 cycles; ack in cycle 5 with 0xDEADBEEF.
- Read of an unmapped address: requestOutput=0, dataRead=0xFFFFFFFF -> wb_error_o for one cycle in cycle 2; wb_ack_o stays 0.
- TIMEOUT_CYCLES=4 with busy stuck high -> wb_error_o in cycle 6, wb_data_o=0xFFFFFFFF, strobes low in cycle 6.
- Drop wb_cyc_i during a busy access, then separately assert rst during ACCESS -> both cases return to IDLE with no ack or error; all strobes 0 on the next cycle; the next transfer completes normally.
